// File: rtl/csr_file_m_if.sv
// ---------------------------------------------------------------------------
// csr_file_m_if
// Bundles the execute/writeback-stage signals between the core pipeline and
// the machine-mode CSR file (csr_file_m).
//
// Signals (direction seen from the CSR file, i.e. the slave modport):
//   csr_addr    in   12    CSR address (inst[31:20])
//   csr_wdata   in   XLEN  rs1 value or zero-extended uimm
//   csr_op      in   2     01=write, 10=set, 11=clear, 00=none
//   csr_wr      in   1     CSR write enable for this instruction
//   csr_rd      in   1     CSR read enable for this instruction
//   inst_valid  in   1     instruction boundary, interrupts sampled here
//   pc          in   XLEN  PC of the instruction at the boundary
//   is_mret     in   1     mret executing this cycle
//   timer_irq   in   1     machine timer interrupt level
//   ext_irq     in   NUM_EXT_IRQ external interrupt levels
//   rdata       out  XLEN  CSR read data (combinational)
//   trap_taken  out  1     redirect fetch to trap_pc this cycle
//   trap_pc     out  XLEN  trap handler target
//   epc         out  XLEN  mepc, mret redirect target
//   csr_illegal out  1     access to an unimplemented CSR address
// ---------------------------------------------------------------------------
interface csr_file_m_if #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_EXT_IRQ = 1
);
    logic [11:0]            csr_addr;
    logic [XLEN-1:0]        csr_wdata;
    logic [1:0]             csr_op;
    logic                   csr_wr;
    logic                   csr_rd;
    logic                   inst_valid;
    logic [XLEN-1:0]        pc;
    logic                   is_mret;
    logic                   timer_irq;
    logic [NUM_EXT_IRQ-1:0] ext_irq;
    logic [XLEN-1:0]        rdata;
    logic                   trap_taken;
    logic [XLEN-1:0]        trap_pc;
    logic [XLEN-1:0]        epc;
    logic                   csr_illegal;

    // Pipeline side: drives the access and interrupt inputs.
    modport master (
        output csr_addr, csr_wdata, csr_op, csr_wr, csr_rd,
        output inst_valid, pc, is_mret, timer_irq, ext_irq,
        input  rdata, trap_taken, trap_pc, epc, csr_illegal
    );

    // CSR file side.
    modport slave (
        input  csr_addr, csr_wdata, csr_op, csr_wr, csr_rd,
        input  inst_valid, pc, is_mret, timer_irq, ext_irq,
        output rdata, trap_taken, trap_pc, epc, csr_illegal
    );
endinterface

// File: rtl/csr_file_m.sv
// ---------------------------------------------------------------------------
// csr_file_m
// Machine-mode CSR file for the RV32 core: mstatus, mie, mip, mtvec, mepc,
// mcause and mscratch with CSRRW/CSRRS/CSRRC semantics, interrupt trap
// entry and mret return.
//
// Ports:
//   clk   in  1   clock, all state updates on the rising edge
//   rst   in  1   synchronous active-high reset
//   bus   csr_file_m_if.slave  access, interrupt and redirect signals
//
// Optional feature macro: CSR_MCYCLE_EN
//   Defined   -> 64-bit mcycle counter at 0xB00 (low) / 0xB80 (high).
//   Undefined -> 0xB00/0xB80 are unimplemented addresses.
// ---------------------------------------------------------------------------
module csr_file_m #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100,
    parameter int unsigned     NUM_EXT_IRQ = 1
) (
    input  logic         clk,
    input  logic         rst,
    csr_file_m_if.slave  bus
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef CSR_MCYCLE_EN
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
`endif

    localparam logic [1:0]  OP_NONE  = 2'b00;
    localparam logic [1:0]  OP_WRITE = 2'b01;
    localparam logic [1:0]  OP_SET   = 2'b10;
    localparam logic [1:0]  OP_CLEAR = 2'b11;

    localparam logic [3:0]  CAUSE_MTI = 4'd7;
    localparam logic [3:0]  CAUSE_MEI = 4'd11;

    // Instruction addresses are word aligned; low two bits never stored.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Read-modify-write result of a CSR instruction on an old value.
    function automatic logic [XLEN-1:0] csr_apply(
        input logic [1:0]      op,
        input logic [XLEN-1:0] old_v,
        input logic [XLEN-1:0] wdata_v
    );
        logic [XLEN-1:0] res;
        case (op)
            OP_WRITE: res = wdata_v;
            OP_SET:   res = old_v | wdata_v;
            OP_CLEAR: res = old_v & ~wdata_v;
            default:  res = old_v;
        endcase
        return res;
    endfunction

    // Architectural state.
    logic            mstatus_mie_q,  mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic            mie_mtie_q,     mie_mtie_d;
    logic            mie_meie_q,     mie_meie_d;
    logic [XLEN-1:0] mtvec_q,        mtvec_d;
    logic [XLEN-1:0] mscratch_q,     mscratch_d;
    logic [XLEN-1:0] mepc_q,         mepc_d;
    logic [XLEN-1:0] mcause_q,       mcause_d;
`ifdef CSR_MCYCLE_EN
    logic [63:0]     mcycle_q,       mcycle_d;
`endif

    // Combinational helpers.
    logic            mip_mtip_s;
    logic            mip_meip_s;
    logic            ext_pend_s;
    logic            tmr_pend_s;
    logic            pend_s;
    logic            trap_s;
    logic [3:0]      cause_s;
    logic [XLEN-1:0] tvec_base_s;
    logic [XLEN-1:0] trap_pc_s;
    logic [XLEN-1:0] mstatus_s;
    logic [XLEN-1:0] mie_s;
    logic [XLEN-1:0] mip_s;
    logic [XLEN-1:0] old_s;
    logic [XLEN-1:0] new_s;
    logic            impl_s;
    logic            wr_active_s;

    assign mip_mtip_s = bus.timer_irq;
    assign mip_meip_s = |bus.ext_irq;

    // Assemble the sparse CSR views; unimplemented bits read as zero.
    always_comb begin
        mstatus_s     = {XLEN{1'b0}};
        mstatus_s[3]  = mstatus_mie_q;
        mstatus_s[7]  = mstatus_mpie_q;
        mie_s         = {XLEN{1'b0}};
        mie_s[7]      = mie_mtie_q;
        mie_s[11]     = mie_meie_q;
        mip_s         = {XLEN{1'b0}};
        mip_s[7]      = mip_mtip_s;
        mip_s[11]     = mip_meip_s;
    end

    // Address decode: current (pre-write) value and implemented flag.
    always_comb begin
        old_s  = {XLEN{1'b0}};
        impl_s = 1'b1;
        case (bus.csr_addr)
            ADDR_MSTATUS:  old_s = mstatus_s;
            ADDR_MIE:      old_s = mie_s;
            ADDR_MTVEC:    old_s = mtvec_q;
            ADDR_MSCRATCH: old_s = mscratch_q;
            ADDR_MEPC:     old_s = mepc_q;
            ADDR_MCAUSE:   old_s = mcause_q;
            ADDR_MIP:      old_s = mip_s;
`ifdef CSR_MCYCLE_EN
            ADDR_MCYCLE:   old_s = XLEN'(mcycle_q[31:0]);
            ADDR_MCYCLEH:  old_s = XLEN'(mcycle_q[63:32]);
`endif
            default:       impl_s = 1'b0;
        endcase
    end

    // Write qualification: set/clear with a zero mask is a pure read.
    always_comb begin
        new_s = csr_apply(bus.csr_op, old_s, bus.csr_wdata);
        if (bus.csr_op == OP_NONE) begin
            wr_active_s = 1'b0;
        end else if (bus.csr_op == OP_WRITE) begin
            wr_active_s = bus.csr_wr;
        end else begin
            wr_active_s = bus.csr_wr & (bus.csr_wdata != {XLEN{1'b0}});
        end
    end

    // Interrupt arbitration and trap target; external beats timer.
    always_comb begin
        ext_pend_s  = mie_meie_q & mip_meip_s;
        tmr_pend_s  = mie_mtie_q & mip_mtip_s;
        pend_s      = mstatus_mie_q & (ext_pend_s | tmr_pend_s);
        // mret suppresses the trap; the restored MIE is seen next cycle.
        trap_s      = pend_s & bus.inst_valid & ~bus.is_mret & ~rst;
        if (ext_pend_s) begin
            cause_s = CAUSE_MEI;
        end else begin
            cause_s = CAUSE_MTI;
        end
        tvec_base_s = mtvec_q & ALIGN_MASK;
        // Only mode 01 vectors; modes 10/11 fall back to direct.
        if (mtvec_q[1:0] == 2'b01) begin
            trap_pc_s = tvec_base_s + {{(XLEN-6){1'b0}}, cause_s, 2'b00};
        end else begin
            trap_pc_s = tvec_base_s;
        end
    end

    // Next-state for the trap/mret/CSR-write paths; a trap discards the write.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        if (trap_s) begin
            mepc_d         = bus.pc & ALIGN_MASK;
            mcause_d       = {1'b1, {(XLEN-5){1'b0}}, cause_s};
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else begin
            if (wr_active_s) begin
                case (bus.csr_addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie_d  = new_s[3];
                        mstatus_mpie_d = new_s[7];
                    end
                    ADDR_MIE: begin
                        mie_mtie_d = new_s[7];
                        mie_meie_d = new_s[11];
                    end
                    ADDR_MTVEC:    mtvec_d    = new_s;
                    ADDR_MSCRATCH: mscratch_d = new_s;
                    ADDR_MEPC:     mepc_d     = new_s & ALIGN_MASK;
                    ADDR_MCAUSE:   mcause_d   = new_s;
                    // mip is read-only and other addresses hold no state here.
                    default:       mscratch_d = mscratch_q;
                endcase
            end else begin
                mscratch_d = mscratch_q;
            end
            // mret restores the interrupt enable stack over any mstatus write.
            if (bus.is_mret) begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end else begin
                mstatus_mpie_d = mstatus_mpie_d;
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    // mcycle: free-running, except a software write to a half replaces it.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (wr_active_s & ~trap_s) begin
            case (bus.csr_addr)
                ADDR_MCYCLE:  mcycle_d = {mcycle_q[63:32], new_s[31:0]};
                ADDR_MCYCLEH: mcycle_d = {new_s[31:0], mcycle_q[31:0]};
                default:      mcycle_d = mcycle_q + 64'd1;
            endcase
        end else begin
            mcycle_d = mcycle_q + 64'd1;
        end
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= {XLEN{1'b0}};
            mepc_q         <= {XLEN{1'b0}};
            mcause_q       <= {XLEN{1'b0}};
`ifdef CSR_MCYCLE_EN
            mcycle_q       <= 64'd0;
`endif
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
`ifdef CSR_MCYCLE_EN
            mcycle_q       <= mcycle_d;
`endif
        end
    end

    assign bus.rdata       = bus.csr_rd ? old_s : {XLEN{1'b0}};
    assign bus.csr_illegal = (bus.csr_rd | bus.csr_wr) & ~impl_s;
    assign bus.trap_taken  = trap_s;
    assign bus.trap_pc     = trap_pc_s;
    assign bus.epc         = mepc_q;

endmodule

// File: tb/tb_csr_file_m.sv
// ---------------------------------------------------------------------------
// tb_csr_file_m
// Self-checking bench for csr_file_m: directed scenarios followed by a
// randomized run, all checked against an address-keyed CSR model.
// Honours CSR_MCYCLE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_csr_file_m;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    csr_file_m_if #(.XLEN(32), .NUM_EXT_IRQ(1)) bus ();

    csr_file_m #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0100),
        .NUM_EXT_IRQ (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] csr_m [logic [11:0]];   // stored CSR words by address
    logic [31:0] wmask [logic [11:0]];   // writable bits per address
    logic [63:0] mcyc;

    function automatic void model_reset();
        csr_m[12'h300] = 32'h0;
        csr_m[12'h304] = 32'h0;
        csr_m[12'h305] = 32'h0000_0100;
        csr_m[12'h340] = 32'h0;
        csr_m[12'h341] = 32'h0;
        csr_m[12'h342] = 32'h0;
        wmask[12'h300] = 32'h0000_0088;
        wmask[12'h304] = 32'h0000_0880;
        wmask[12'h305] = 32'hFFFF_FFFF;
        wmask[12'h340] = 32'hFFFF_FFFF;
        wmask[12'h341] = 32'hFFFF_FFFC;
        wmask[12'h342] = 32'hFFFF_FFFF;
        mcyc = 64'd0;
    endfunction

    function automatic bit model_impl(input logic [11:0] a);
        bit r;
        r = (a == 12'h344) || csr_m.exists(a);
`ifdef CSR_MCYCLE_EN
        r = r || (a == 12'hB00) || (a == 12'hB80);
`endif
        return r;
    endfunction

    function automatic logic [31:0] model_value(input logic [11:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (a == 12'h344) begin
            v[7]  = bus.timer_irq;
            v[11] = (bus.ext_irq != 1'b0);
        end else if (csr_m.exists(a)) begin
            v = csr_m[a];
        end
`ifdef CSR_MCYCLE_EN
        if (a == 12'hB00) v = mcyc[31:0];
        if (a == 12'hB80) v = mcyc[63:32];
`endif
        return v;
    endfunction

    function automatic bit model_ext_pend();
        logic [31:0] ie;
        ie = csr_m[12'h304];
        return ie[11] && (bus.ext_irq != 1'b0);
    endfunction

    function automatic bit model_trap();
        logic [31:0] st, ie;
        st = csr_m[12'h300];
        ie = csr_m[12'h304];
        return !rst && bus.inst_valid && !bus.is_mret && st[3] &&
               (model_ext_pend() || (ie[7] && bus.timer_irq));
    endfunction

    function automatic logic [31:0] model_cause();
        return model_ext_pend() ? 32'd11 : 32'd7;
    endfunction

    function automatic logic [31:0] model_trap_pc();
        logic [31:0] tv;
        tv = csr_m[12'h305];
        if (tv[1:0] == 2'b01) return (tv & 32'hFFFF_FFFC) + 32'd4 * model_cause();
        return tv & 32'hFFFF_FFFC;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    function automatic void model_clock();
        logic [31:0] st, oldv, nv;
        bit          wrote_cyc;
        wrote_cyc = 1'b0;
        if (rst) begin
            model_reset();
            return;
        end
        st = csr_m[12'h300];
        if (model_trap()) begin
            csr_m[12'h341] = bus.pc & 32'hFFFF_FFFC;
            csr_m[12'h342] = 32'h8000_0000 | model_cause();
            csr_m[12'h300] = st[3] ? 32'h80 : 32'h0;
        end else begin
            if (bus.csr_wr && model_impl(bus.csr_addr) && bus.csr_op != 2'b00 &&
                !(bus.csr_op != 2'b01 && bus.csr_wdata == 32'h0)) begin
                oldv = model_value(bus.csr_addr);
                case (bus.csr_op)
                    2'b01:   nv = bus.csr_wdata;
                    2'b10:   nv = oldv | bus.csr_wdata;
                    default: nv = oldv & ~bus.csr_wdata;
                endcase
                if (csr_m.exists(bus.csr_addr)) begin
                    csr_m[bus.csr_addr] = nv & wmask[bus.csr_addr];
                end else if (bus.csr_addr == 12'hB00) begin
                    mcyc[31:0] = nv;
                    wrote_cyc  = 1'b1;
                end else if (bus.csr_addr == 12'hB80) begin
                    mcyc[63:32] = nv;
                    wrote_cyc   = 1'b1;
                end
            end
            if (bus.is_mret) begin
                csr_m[12'h300] = 32'h80 | (st[7] ? 32'h8 : 32'h0);
            end
        end
        if (!wrote_cyc) mcyc = mcyc + 64'd1;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.csr_addr   = 12'h000;
        bus.csr_wdata  = 32'h0;
        bus.csr_op     = 2'b00;
        bus.csr_wr     = 1'b0;
        bus.csr_rd     = 1'b0;
        bus.inst_valid = 1'b0;
        bus.pc         = 32'h0;
        bus.is_mret    = 1'b0;
    endtask

    task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        bus.csr_addr  = a;
        bus.csr_op    = op;
        bus.csr_wdata = d;
        bus.csr_wr    = 1'b1;
        bus.csr_rd    = 1'b1;
    endtask

    task automatic peek(input logic [11:0] a);
        bus.csr_addr = a;
        bus.csr_op   = 2'b00;
        bus.csr_wr   = 1'b0;
        bus.csr_rd   = 1'b1;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_bus();
        bus.timer_irq = 1'b0;
        bus.ext_irq   = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        peek(12'h305);
        total++; if (bus.rdata !== 32'h0000_0100) begin bad++; $display("FAIL reset_mtvec: got %h want %h", bus.rdata, 32'h0000_0100); end
        peek(12'h300);
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL reset_mstatus: got %h want %h", bus.rdata, 32'h0); end
        total++; if (bus.trap_taken !== 1'b0) begin bad++; $display("FAIL reset_trap_taken: got %b want 0", bus.trap_taken); end
        total++; if (bus.epc !== 32'h0) begin bad++; $display("FAIL reset_epc: got %h want 0", bus.epc); end
        idle_bus();
    endtask

    task automatic test_ext_trap();
        csr(12'h304, 2'b01, 32'h800); cycle();
        csr(12'h300, 2'b10, 32'h8);   cycle();
        idle_bus();
        bus.ext_irq = 1'b1; bus.inst_valid = 1'b1; bus.pc = 32'h40;
        #1;
        total++; if (bus.trap_taken !== 1'b1) begin bad++; $display("FAIL ext_trap_taken: got %b want 1", bus.trap_taken); end
        total++; if (bus.trap_pc !== 32'h100) begin bad++; $display("FAIL ext_trap_pc: got %h want %h", bus.trap_pc, 32'h100); end
        cycle();
        // level still high and inst_valid high: MIE is now 0, no retrigger
        bus.pc = 32'h44;
        peek(12'h341);
        total++; if (bus.rdata !== 32'h40) begin bad++; $display("FAIL ext_mepc: got %h want %h", bus.rdata, 32'h40); end
        peek(12'h342);
        total++; if (bus.rdata !== 32'h8000_000B) begin bad++; $display("FAIL ext_mcause: got %h want %h", bus.rdata, 32'h8000_000B); end
        peek(12'h300);
        total++; if (bus.rdata !== 32'h80) begin bad++; $display("FAIL ext_mstatus: got %h want %h", bus.rdata, 32'h80); end
        total++; if (bus.trap_taken !== 1'b0) begin bad++; $display("FAIL back_to_back: got %b want 0", bus.trap_taken); end
        cycle();
        idle_bus();
        bus.ext_irq = 1'b0;
    endtask

    task automatic test_vectored();
        csr(12'h305, 2'b01, 32'h201); cycle();
        csr(12'h304, 2'b01, 32'h880); cycle();
        csr(12'h300, 2'b10, 32'h8);   cycle();
        idle_bus();
        bus.timer_irq = 1'b1; bus.inst_valid = 1'b1; bus.pc = 32'h80;
        #1;
        total++; if (bus.trap_pc !== 32'h21C) begin bad++; $display("FAIL vec_timer_pc: got %h want %h", bus.trap_pc, 32'h21C); end
        cycle();
        bus.inst_valid = 1'b0;
        peek(12'h342);
        total++; if (bus.rdata !== 32'h8000_0007) begin bad++; $display("FAIL vec_timer_cause: got %h want %h", bus.rdata, 32'h8000_0007); end
        csr(12'h300, 2'b10, 32'h8); cycle();
        idle_bus();
        bus.ext_irq = 1'b1; bus.inst_valid = 1'b1; bus.pc = 32'h84;
        #1;
        total++; if (bus.trap_pc !== 32'h22C) begin bad++; $display("FAIL vec_ext_pc: got %h want %h", bus.trap_pc, 32'h22C); end
        cycle();
        bus.inst_valid = 1'b0;
        peek(12'h342);
        total++; if (bus.rdata !== 32'h8000_000B) begin bad++; $display("FAIL vec_ext_cause: got %h want %h", bus.rdata, 32'h8000_000B); end
        idle_bus();
        bus.ext_irq = 1'b0; bus.timer_irq = 1'b0;
    endtask

    task automatic test_mret();
        csr(12'h305, 2'b01, 32'h100); cycle();
        csr(12'h300, 2'b10, 32'h8);   cycle();
        idle_bus();
        bus.ext_irq = 1'b1; bus.inst_valid = 1'b1; bus.pc = 32'h40;
        cycle();
        bus.is_mret = 1'b1;
        #1;
        total++; if (bus.epc !== 32'h40) begin bad++; $display("FAIL mret_epc: got %h want %h", bus.epc, 32'h40); end
        cycle();
        // MIE restored and interrupt pending, but mret still held
        peek(12'h300);
        total++; if (bus.rdata !== 32'h88) begin bad++; $display("FAIL mret_mstatus: got %h want %h", bus.rdata, 32'h88); end
        total++; if (bus.trap_taken !== 1'b0) begin bad++; $display("FAIL mret_blocks_trap: got %b want 0", bus.trap_taken); end
        cycle();
        bus.is_mret = 1'b0;
        #1;
        total++; if (bus.trap_taken !== 1'b1) begin bad++; $display("FAIL post_mret_trap: got %b want 1", bus.trap_taken); end
        idle_bus();
        bus.ext_irq = 1'b0;
        cycle();
    endtask

    task automatic test_csr_ops();
        csr(12'h340, 2'b01, 32'hFFFF_0000);
        #1;
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL csrrw_old_value: got %h want 0", bus.rdata); end
        cycle();
        csr(12'h340, 2'b11, 32'h0F00_0000); cycle();
        peek(12'h340);
        total++; if (bus.rdata !== 32'hF0FF_0000) begin bad++; $display("FAIL clear_mscratch: got %h want %h", bus.rdata, 32'hF0FF_0000); end
        csr(12'h340, 2'b10, 32'h0); cycle();
        csr(12'h340, 2'b00, 32'h1234); cycle();
        peek(12'h340);
        total++; if (bus.rdata !== 32'hF0FF_0000) begin bad++; $display("FAIL no_write_ops: got %h want %h", bus.rdata, 32'hF0FF_0000); end
        csr(12'h344, 2'b01, 32'hFFFF_FFFF); cycle();
        peek(12'h344);
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL mip_readonly: got %h want 0", bus.rdata); end
        bus.timer_irq = 1'b1;
        peek(12'h344);
        total++; if (bus.rdata !== 32'h80) begin bad++; $display("FAIL mip_mtip: got %h want %h", bus.rdata, 32'h80); end
        bus.timer_irq = 1'b0;
        peek(12'h7C0);
        total++; if (bus.rdata !== 32'h0 || bus.csr_illegal !== 1'b1) begin bad++; $display("FAIL illegal_7c0: rdata %h illegal %b want 0/1", bus.rdata, bus.csr_illegal); end
        bus.csr_rd = 1'b0; bus.csr_addr = 12'h340;
        #1;
        total++; if (bus.rdata !== 32'h0 || bus.csr_illegal !== 1'b0) begin bad++; $display("FAIL rd_low: rdata %h illegal %b want 0/0", bus.rdata, bus.csr_illegal); end
        csr(12'h341, 2'b01, 32'h123); cycle();
        peek(12'h341);
        total++; if (bus.rdata !== 32'h120) begin bad++; $display("FAIL mepc_align: got %h want %h", bus.rdata, 32'h120); end
`ifndef CSR_MCYCLE_EN
        peek(12'hB00);
        total++; if (bus.rdata !== 32'h0 || bus.csr_illegal !== 1'b1) begin bad++; $display("FAIL mcycle_absent: rdata %h illegal %b want 0/1", bus.rdata, bus.csr_illegal); end
`endif
        idle_bus();
    endtask

    task automatic test_trap_priority();
        csr(12'h300, 2'b10, 32'h8); cycle();
        idle_bus();
        bus.timer_irq = 1'b1; bus.inst_valid = 1'b1; bus.pc = 32'h1000;
        csr(12'h340, 2'b01, 32'hDEAD_BEEF);
        #1;
        total++; if (bus.trap_taken !== 1'b1) begin bad++; $display("FAIL trap_with_write: got %b want 1", bus.trap_taken); end
        cycle();
        bus.inst_valid = 1'b0;
        peek(12'h340);
        total++; if (bus.rdata !== 32'hF0FF_0000) begin bad++; $display("FAIL write_discarded: got %h want %h", bus.rdata, 32'hF0FF_0000); end
        csr(12'h300, 2'b10, 32'h8); cycle();
        idle_bus();
        bus.inst_valid = 1'b1; bus.pc = 32'h2000; rst = 1'b1;
        #1;
        total++; if (bus.trap_taken !== 1'b0) begin bad++; $display("FAIL rst_trap_taken: got %b want 0", bus.trap_taken); end
        cycle();
        rst = 1'b0;
        idle_bus();
        peek(12'h341);
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_wins_mepc: got %h want 0", bus.rdata); end
        peek(12'h300);
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_wins_mstatus: got %h want 0", bus.rdata); end
        bus.timer_irq = 1'b0;
        idle_bus();
    endtask

`ifdef CSR_MCYCLE_EN
    task automatic test_mcycle();
        csr(12'hB00, 2'b01, 32'hFFFF_FFFF); cycle();
        csr(12'hB80, 2'b01, 32'h0);         cycle();
        idle_bus();
        cycle();
        peek(12'hB80);
        total++; if (bus.rdata !== 32'h1) begin bad++; $display("FAIL mcycle_hi: got %h want 1", bus.rdata); end
        peek(12'hB00);
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL mcycle_lo: got %h want 0", bus.rdata); end
        idle_bus();
    endtask
`endif

    task automatic test_random();
        logic [11:0] addrs [10];
        logic [31:0] exp_rd;
        bit          exp_ill;
        bit          exp_trap;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h344, 12'hB00, 12'hB80, 12'h7C0};
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 49) == 0);
            bus.csr_addr   = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 9)];
            bus.csr_op     = 2'($urandom);
            bus.csr_wdata  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            bus.csr_wr     = 1'($urandom);
            bus.csr_rd     = ($urandom_range(0, 9) < 7);
            bus.inst_valid = 1'($urandom);
            bus.is_mret    = ($urandom_range(0, 9) == 0);
            bus.timer_irq  = ($urandom_range(0, 2) == 0);
            bus.ext_irq    = ($urandom_range(0, 2) == 0);
            bus.pc         = 32'($urandom);
            #1;
            exp_rd   = bus.csr_rd ? model_value(bus.csr_addr) : 32'h0;
            exp_ill  = (bus.csr_rd || bus.csr_wr) && !model_impl(bus.csr_addr);
            exp_trap = model_trap();
            total++; if (bus.rdata !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d] addr %h: got %h want %h", i, bus.csr_addr, bus.rdata, exp_rd); end
            total++; if (bus.csr_illegal !== exp_ill) begin bad++; $display("FAIL rand_illegal[%0d]: got %b want %b", i, bus.csr_illegal, exp_ill); end
            total++; if (bus.trap_taken !== exp_trap) begin bad++; $display("FAIL rand_trap[%0d]: got %b want %b", i, bus.trap_taken, exp_trap); end
            if (exp_trap) begin
                total++; if (bus.trap_pc !== model_trap_pc()) begin bad++; $display("FAIL rand_trap_pc[%0d]: got %h want %h", i, bus.trap_pc, model_trap_pc()); end
            end
            total++; if (bus.epc !== csr_m[12'h341]) begin bad++; $display("FAIL rand_epc[%0d]: got %h want %h", i, bus.epc, csr_m[12'h341]); end
            cycle();
        end
        rst = 1'b0;
        idle_bus();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_bus();
        bus.timer_irq = 1'b0;
        bus.ext_irq   = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_ext_trap();
        test_vectored();
        test_mret();
        test_csr_ops();
        test_trap_priority();
`ifdef CSR_MCYCLE_EN
        test_mcycle();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_file_m.md
Name: csr_file_m

Overview:
- Parametrised machine-mode CSR file for the RV32 core; successor to the fixed five-entry CSR store.
- Holds mstatus, mie, mip, mtvec, mepc, mcause and mscratch.
- Supports CSRRW/CSRRS/CSRRC semantics, interrupt trap entry and mret return.
- Sits beside the register file in the execute/writeback stage; drives the PC redirect for traps and mret.

Parameters:
XLEN, 32, data width of all CSRs and data ports
MTVEC_RESET, 32'h0000_0100, reset value of mtvec (base plus mode bits)
NUM_EXT_IRQ, 1, number of external interrupt request lines, OR-reduced into mip.MEIP

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
csr_addr  input  12  CSR address (inst[31:20])
csr_wdata  input  XLEN  rs1 value or zero-extended uimm
csr_op  input  2  01=write, 10=set, 11=clear, 00=none
csr_wr  input  1  CSR write enable for this instruction
csr_rd  input  1  CSR read enable for this instruction
inst_valid  input  1  instruction boundary; interrupts sampled only when high
pc  input  XLEN  PC of the instruction at the boundary
is_mret  input  1  mret executing this cycle
timer_irq  input  1  machine timer interrupt level
ext_irq  input  NUM_EXT_IRQ  external interrupt levels
rdata  output  XLEN  CSR read data, combinational
trap_taken  output  1  one-cycle pulse: redirect fetch to trap_pc
trap_pc  output  XLEN  handler target address
epc  output  XLEN  mepc value, mret redirect target
csr_illegal  output  1  access to an unimplemented address while csr_rd or csr_wr is high

Behaviour:
- Reset (synchronous, rst high at posedge):
  - mstatus=0, mie=0, mepc=0, mcause=0, mscratch=0, mtvec=MTVEC_RESET.
  - Outputs trap_taken=0 and epc=0.
- Addresses:
  - mstatus 0x300 (implemented bits MIE[3] and MPIE[7] only; all other bits read 0).
  - mie 0x304 (MTIE[7], MEIE[11]).
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341 (bits [1:0] forced 0).
  - mcause 0x342.
  - mip 0x344 (read-only: MTIP=timer_irq, MEIP=|ext_irq; writes ignored).
- Read:
  - rdata is valid in the same cycle.
  - rdata=0 when csr_rd=0 or the address is unimplemented; csr_illegal=1 in the unimplemented case.
  - rdata always returns the pre-write value (old value for CSRRW).
- Write:
  - New value = wdata, old|wdata, or old&~wdata for csr_op 01/10/11; applied at posedge when csr_wr=1.
  - csr_op=00 writes nothing.
  - Set/clear with wdata=0 writes nothing.
- Interrupt pending (pend):
  - pend = mstatus.MIE & ((mie.MEIE & MEIP) | (mie.MTIE & MTIP)).
  - Priority: external (cause 11) over timer (cause 7).
- Trap entry, when pend & inst_valid & !is_mret:
  - trap_taken=1 combinationally in that cycle.
  - At the posedge: mepc<=pc, mcause<={1'b1, cause}, MPIE<=MIE, MIE<=0.
  - A CSR write in the same cycle is discarded; the trap wins.
- trap_pc:
  - mtvec[1:0]=00 (direct): {mtvec[XLEN-1:2], 2'b00}.
  - mtvec[1:0]=01 (vectored): base + 4*cause.
  - Modes 10/11 behave as direct.
- mret (is_mret=1):
  - At the posedge: MIE<=MPIE, MPIE<=1.
  - epc = mepc continuously.
  - No trap in the mret cycle; pend is re-evaluated the next cycle with the restored MIE.
- Back-to-back: after trap entry MIE=0, so a level that stays asserted cannot retrigger until the handler sets MIE or executes mret.
- rst during the trap cycle: reset wins, no CSR update.

Optional Feature:
CSR_MCYCLE_EN
- Defined:
  - Adds a 64-bit mcycle counter, reset 0, incrementing every cycle when not in reset and wrapping at 2^64-1 to 0.
  - mcycle is readable at 0xB00 (low) and 0xB80 (high) and writable with the same csr_op rules.
  - A write to either half replaces that half for that cycle; no increment in that cycle.
- Undefined: 0xB00 and 0xB80 are unimplemented (rdata=0, csr_illegal=1).

Test Plan:
- rst, then read 0x305 -> rdata=0x0000_0100. Read 0x300 -> 0.
- Write mie=0x800, set mstatus with 0x8, ext_irq=1, inst_valid=1, pc=0x40 -> trap_taken=1, trap_pc=0x100; next cycle mepc=0x40, mcause=0x8000_000B, mstatus=0x80.
- mtvec=0x201 (vectored), timer_irq=1 with MTIE and MIE set -> trap_pc=0x21C, mcause=0x8000_0007. With ext_irq also high -> cause 11, trap_pc=0x22C.
- After a trap, is_mret=1 -> epc=0x40, mstatus=0x88 next cycle; is_mret held with an interrupt pending -> no trap_taken in that cycle.
- Write 0xFFFF_0000 to mscratch, then clear with 0x0F00_0000 -> read 0xF0FF_0000. Write 0x344 -> unchanged. Read 0x7C0 -> rdata=0, csr_illegal=1.
- (CSR_MCYCLE_EN) Write 0xB00=0xFFFF_FFFF, 0xB80=0 -> two cycles later 0xB80 reads 1 and 0xB00 reads 0x0000_0000.
